list_cmd_master: RTL and testbench
==================================

// Module: list_cmd_master
// PURPOSE
//  Initiator for the list op interface (op_sel/op_en/data_in/index_in -> data_out/op_done/op_in_progress/op_error).
//  Accepts commands on a valid/ready stream, issues one op to the list, and waits for completion.
//  Buffers the result(s), including multi-result find-all, and returns them on a valid/ready response stream.
//  Sits between a host/CSR bridge and a list instance; one command outstanding at a time.
// PARAMETERS
//  DATA_WIDTH      32    element width; must match the list
//  LENGTH          8     list depth; must match the list; also the find-all result buffer depth
//  TIMEOUT_CYCLES  1024  WAIT-state cycle limit (used only with LIST_CMD_TIMEOUT_EN)
//  LENGTH_WIDTH    localparam $clog2(LENGTH+1)
// PORTS
//  clk             in   1                    clock, rising edge
//  rst_n           in   1                    asynchronous active-low reset
//  cmd_valid       in   1                    command present
//  cmd_ready       out  1                    command accepted when valid&ready
//  cmd_op          in   3                    0 rd, 1 wr, 2 find_all, 3 find_1st, 4 sum, 5 sort_asc, 6 sort_des, 7 reserved
//  cmd_data        in   DATA_WIDTH           write data / search key
//  cmd_index       in   LENGTH_WIDTH         read/write index
//  rsp_valid       out  1                    response present
//  rsp_ready       in   1                    response consumed when valid&ready
//  rsp_data        out  LENGTH_WIDTH+DATA_WIDTH  result (read data, index, or sum)
//  rsp_error       out  1                    command failed
//  rsp_last        out  1                    final response beat of the command
//  op_sel          out  3                    to list
//  op_en           out  1                    to list, single-cycle pulse
//  data_in         out  DATA_WIDTH           to list
//  index_in        out  LENGTH_WIDTH         to list
//  data_out        in   LENGTH_WIDTH+DATA_WIDTH  from list
//  op_done         in   1                    from list
//  op_in_progress  in   1                    from list
//  op_error        in   1                    from list
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, result buffer empty. Reset mid-op discards the op and all buffered results.
//    The list is reset by the same rst_n.
//  States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  - IDLE: cmd_ready=1. On accept, latch op/data/index.
//    Reject locally, with no op_en: op 7, or rd/wr with cmd_index>LENGTH-1.
//    A rejected command goes to RESP with one beat: rsp_error=1, rsp_data=0, rsp_last=1.
//  - ISSUE (1 cycle): op_en=1. op_sel/data_in/index_in are driven from the latch and held stable from ISSUE until WAIT exits.
//  - WAIT: completion event (CE) = op_done==1, or op_in_progress falling 1->0 (registered prev value).
//    - Non-find_all: the first CE captures data_out/op_error into one beat; go to RESP.
//    - find_all: each cycle with op_done==1 && op_error==0 pushes data_out into the result FIFO (depth LENGTH).
//      Terminal = CE with op_in_progress==0; a match on the terminal cycle is also pushed.
//      At terminal, if the FIFO is empty, push one error beat (rsp_error=1, data 0).
//    - Write: rsp_data=0 on success.
//  - RESP: rsp_valid=1 while beats remain. A beat pops on rsp_valid&rsp_ready.
//    rsp_last=1 on the final beat. IDLE follows the last handshake.
//    rsp_* are held stable under backpressure.
//  - Latency: accept at edge N -> op_en high in cycle N+1. rsp_valid is earliest one cycle after the CE cycle.
//  - cmd_ready=0 in every state except IDLE. No command pipelining.
//  - FIFO cannot overflow (at most LENGTH matches). Pointers wrap modulo LENGTH; count is LENGTH_WIDTH bits.
//  - Inputs from the list are ignored outside WAIT.
// CONFIGURATION
//  LIST_CMD_TIMEOUT_EN defined:
//    - A WAIT counter clears on entry and on every find_all push.
//    - On reaching TIMEOUT_CYCLES with no terminal CE: emit buffered beats, then a final error beat (rsp_error=1, rsp_last=1).
//    - Go to RESP.
//  Not defined: no counter; WAIT persists until a CE.
// TESTING
//  1. wr idx3=0xA5, then rd idx3 -> wr beat err=0; rd beat rsp_data=0xA5, last=1.
//  2. Store 7 at idx 1,4,6; find_all key 7 -> 3 beats, data 1,4,6, last only on 6, err=0.
//  3. find_1st key 0x55 with no match -> 1 beat, err=1, last=1.
//  4. sum with idx0..7 = 1..8 -> rsp_data=36. Same result with rsp_ready held low 5 cycles; rsp_* stable throughout.
//  5. cmd_op=7, and rd with cmd_index=8 (LENGTH=8) -> error beat each, op_en never asserted.
//  6. TIMEOUT_EN, TIMEOUT_CYCLES=16, list stubbed silent -> error beat 16 cycles after WAIT entry; rst_n low mid-WAIT -> all outputs 0 at once.

Source files
------------

// File: rtl/list_cmd_master.sv
// Command/response front end for a list op engine: one op outstanding, results buffered for replay.
// Optional WAIT-state timeout is enabled by defining LIST_CMD_TIMEOUT_EN.
module list_cmd_master #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned LENGTH         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned LENGTH_WIDTH  = $clog2(LENGTH + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [2:0]                       cmd_op,
  input  logic [DATA_WIDTH-1:0]            cmd_data,
  input  logic [LENGTH_WIDTH-1:0]          cmd_index,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [LENGTH_WIDTH+DATA_WIDTH-1:0] rsp_data,
  output logic                             rsp_error,
  output logic                             rsp_last,
  output logic [2:0]                       op_sel,
  output logic                             op_en,
  output logic [DATA_WIDTH-1:0]            data_in,
  output logic [LENGTH_WIDTH-1:0]          index_in,
  input  logic [LENGTH_WIDTH+DATA_WIDTH-1:0] data_out,
  input  logic                             op_done,
  input  logic                             op_in_progress,
  input  logic                             op_error
);

  localparam int unsigned RW = LENGTH_WIDTH + DATA_WIDTH;
  localparam int unsigned PW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [LENGTH_WIDTH-1:0] MaxIndex = LENGTH_WIDTH'(LENGTH - 1);
  localparam logic [PW-1:0]           LastPtr  = PW'(LENGTH - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  localparam logic [2:0] OpWr      = 3'd1;
  localparam logic [2:0] OpFindAll = 3'd2;
  localparam logic [2:0] OpRsvd    = 3'd7;

  logic [1:0]              state_q, state_d;
  logic [2:0]              op_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [LENGTH_WIDTH-1:0] index_q;
  logic                    busy_prev_q;
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [LENGTH_WIDTH-1:0] count_q;
  // Error beat queued behind the buffered results after a timeout
  logic                    tail_err_q, tail_err_d;
  logic [RW:0]             mem [LENGTH];
  logic [RW:0]             head;

  logic        accept, reject, ce, match, timeout_hit;
  logic        push, pop;
  logic [RW:0] push_beat;

  assign accept = (state_q == StIdle) && cmd_valid;
  assign reject = (cmd_op == OpRsvd) || ((cmd_op <= OpWr) && (cmd_index > MaxIndex));
  assign ce     = op_done || (busy_prev_q && !op_in_progress);
  assign match  = op_done && !op_error;
  assign head   = mem[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    tail_err_d = tail_err_q;
    push       = 1'b0;
    push_beat  = '0;
    pop        = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (reject) begin
            push      = 1'b1;
            push_beat = {1'b1, {RW{1'b0}}};
            state_d   = StResp;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (op_q == OpFindAll) begin
          if (match) begin
            push      = 1'b1;
            push_beat = {1'b0, data_out};
          end
          if (ce && !op_in_progress) begin
            if (!match && (count_q == '0)) begin
              push      = 1'b1;
              push_beat = {1'b1, {RW{1'b0}}};
            end
            state_d = StResp;
          end
        end else if (ce) begin
          push      = 1'b1;
          push_beat = {op_error, ((op_q == OpWr) && !op_error) ? {RW{1'b0}} : data_out};
          state_d   = StResp;
        end
        if ((state_d == StWait) && timeout_hit) begin
          tail_err_d = 1'b1;
          state_d    = StResp;
        end
      end
      StResp: begin
        if (rsp_valid && rsp_ready) begin
          if (count_q != '0) pop = 1'b1;
          else               tail_err_d = 1'b0;
          if (rsp_last) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= '0;
      data_q      <= '0;
      index_q     <= '0;
      busy_prev_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tail_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tail_err_q  <= tail_err_d;
      busy_prev_q <= op_in_progress;
      if (accept) begin
        op_q    <= cmd_op;
        data_q  <= cmd_data;
        index_q <= cmd_index;
      end
      if (push) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PW'(1);
      if (push)     count_q <= count_q + LENGTH_WIDTH'(1);
      else if (pop) count_q <= count_q - LENGTH_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_beat;
  end

`ifdef LIST_CMD_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TimeoutLast = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] wait_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else if ((state_q == StIssue) || push) begin
      wait_cnt_q <= '0;
    end else if (state_q == StWait) begin
      wait_cnt_q <= wait_cnt_q + CW'(1);
    end
  end

  assign timeout_hit = (state_q == StWait) && (wait_cnt_q == TimeoutLast);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  // cmd_ready is gated by rst_n so every output reads 0 while reset is held
  assign cmd_ready = (state_q == StIdle) && rst_n;
  assign rsp_valid = (state_q == StResp) && ((count_q != '0) || tail_err_q);
  assign rsp_data  = ((state_q == StResp) && (count_q != '0)) ? head[RW-1:0] : '0;
  assign rsp_error = (state_q == StResp) && ((count_q != '0) ? head[RW] : tail_err_q);
  assign rsp_last  = (state_q == StResp) &&
                     (tail_err_q ? (count_q == '0) : (count_q == LENGTH_WIDTH'(1)));
  assign op_en     = (state_q == StIssue);
  assign op_sel    = op_q;
  assign data_in   = data_q;
  assign index_in  = index_q;

endmodule

// File: tb/tb_list_cmd_master.sv
// Self-checking bench for list_cmd_master: a behavioural list stub drives the op side and an
// array-based model predicts every response beat.
module tb_list_cmd_master;

  localparam int DW  = 32;
  localparam int LEN = 8;
  localparam int TO  = 16;
  localparam int LW  = 4;
  localparam int RW  = LW + DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid, cmd_ready;
  logic [2:0]    cmd_op;
  logic [DW-1:0] cmd_data;
  logic [LW-1:0] cmd_index;
  logic          rsp_valid, rsp_ready;
  logic [RW-1:0] rsp_data;
  logic          rsp_error, rsp_last;
  logic [2:0]    op_sel;
  logic          op_en;
  logic [DW-1:0] data_in;
  logic [LW-1:0] index_in;
  logic [RW-1:0] data_out;
  logic          op_done, op_in_progress, op_error;

  always #5 clk = ~clk;

  list_cmd_master #(
    .DATA_WIDTH    (DW),
    .LENGTH        (LEN),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_data      (cmd_data),
    .cmd_index     (cmd_index),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_error     (rsp_error),
    .rsp_last      (rsp_last),
    .op_sel        (op_sel),
    .op_en         (op_en),
    .data_in       (data_in),
    .index_in      (index_in),
    .data_out      (data_out),
    .op_done       (op_done),
    .op_in_progress(op_in_progress),
    .op_error      (op_error)
  );

  typedef struct packed {
    logic [RW-1:0] data;
    logic          err;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] lmem [LEN];
  int            vectors = 0;
  int            miscompares = 0;
  bit            stub_silent = 1'b0;
  int            en_count = 0;

  function automatic beat_t mk(input logic [RW-1:0] d, input logic e, input logic l);
    beat_t b;
    b.data = d;
    b.err  = e;
    b.last = l;
    return b;
  endfunction

  // ---------------- list stub (the list shares rst_n, so it clears on reset) ----------------
  task automatic run_list_op(input logic [2:0] op, input logic [DW-1:0] key,
                             input logic [LW-1:0] idx);
    int            lat = $urandom_range(1, 3);
    logic [RW-1:0] res = '0;
    logic          err = 1'b0;
    int            hits[$];
    bit            term_on_hit = 1'b0;
    bit            ended = 1'b0;
    logic [DW-1:0] t;
    op_in_progress = 1'b1;
    repeat (lat) @(negedge clk);
    if (op == 3'd2) begin
      term_on_hit = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < LEN; i++) if (lmem[i] == key) hits.push_back(i);
      for (int k = 0; k < hits.size(); k++) begin
        bit fin = term_on_hit && (k == hits.size() - 1);
        op_done = 1'b1;
        op_error = 1'b0;
        data_out = RW'(hits[k]);
        op_in_progress = !fin;
        @(negedge clk);
        op_done = 1'b0;
        data_out = '0;
        if (fin) ended = 1'b1;
        else if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
      if (!ended) begin
        if (hits.size() == 0) begin
          op_done = 1'b1;
          op_error = 1'b1;
        end
        op_in_progress = 1'b0;
        @(negedge clk);
      end
    end else begin
      case (op)
        3'd0: res = (int'(idx) < LEN) ? RW'(lmem[idx]) : '0;
        3'd1: begin
          if (int'(idx) < LEN) lmem[idx] = key;
          res = {$urandom, $urandom};
        end
        3'd3: begin
          err = 1'b1;
          for (int i = LEN - 1; i >= 0; i--) if (lmem[i] == key) begin
            err = 1'b0;
            res = RW'(i);
          end
        end
        3'd4: for (int i = 0; i < LEN; i++) res = res + RW'(lmem[i]);
        default: begin
          for (int i = 0; i < LEN; i++)
            for (int j = 0; j < LEN - 1 - i; j++)
              if ((op == 3'd5) ? (lmem[j] > lmem[j+1]) : (lmem[j] < lmem[j+1])) begin
                t = lmem[j];
                lmem[j] = lmem[j+1];
                lmem[j+1] = t;
              end
        end
      endcase
      // Completion signalled either by op_done or by op_in_progress falling alone
      op_done = ($urandom_range(0, 1) == 1);
      op_in_progress = 1'b0;
      data_out = res;
      op_error = err;
      @(negedge clk);
    end
    op_done = 1'b0;
    op_error = 1'b0;
    op_in_progress = 1'b0;
    data_out = '0;
  endtask

  initial begin : list_stub
    op_done = 1'b0;
    op_in_progress = 1'b0;
    op_error = 1'b0;
    data_out = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int i = 0; i < LEN; i++) lmem[i] = '0;
      end else if (op_en === 1'b1) begin
        en_count++;
        if (!stub_silent) run_list_op(op_sel, data_in, index_in);
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic bit is_reject(input logic [2:0] op, input logic [LW-1:0] idx);
    return (op == 3'd7) || ((op <= 3'd1) && (int'(idx) >= LEN));
  endfunction

  task automatic expect_cmd(input logic [2:0] op, input logic [DW-1:0] key,
                            input logic [LW-1:0] idx);
    logic [RW-1:0] s = '0;
    int            first = -1;
    exp_q.delete();
    if (is_reject(op, idx)) begin
      exp_q.push_back(mk('0, 1'b1, 1'b1));
      return;
    end
    case (op)
      3'd0: exp_q.push_back(mk(RW'(lmem[idx]), 1'b0, 1'b1));
      3'd2: begin
        for (int i = 0; i < LEN; i++) if (lmem[i] == key) exp_q.push_back(mk(RW'(i), 1'b0, 1'b0));
        if (exp_q.size() == 0) exp_q.push_back(mk('0, 1'b1, 1'b1));
        else exp_q[exp_q.size() - 1].last = 1'b1;
      end
      3'd3: begin
        for (int i = 0; i < LEN; i++) if (first < 0 && lmem[i] == key) first = i;
        if (first < 0) exp_q.push_back(mk('0, 1'b1, 1'b1));
        else exp_q.push_back(mk(RW'(first), 1'b0, 1'b1));
      end
      3'd4: begin
        for (int i = 0; i < LEN; i++) s = s + RW'(lmem[i]);
        exp_q.push_back(mk(s, 1'b0, 1'b1));
      end
      default: exp_q.push_back(mk('0, 1'b0, 1'b1));
    endcase
  endtask

  // ---------------- host-side command runner ----------------
  task automatic run_cmd(input logic [2:0] op, input logic [DW-1:0] key,
                         input logic [LW-1:0] idx, input int hold);
    int    budget = 0;
    int    hold_left = hold;
    bit    holding = 1'b0;
    bit    fin = 1'b0;
    bit    rej;
    beat_t cur, held, want;
    rej = is_reject(op, idx);
    expect_cmd(op, key, idx);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_data = key;
    cmd_index = idx;
    while (cmd_ready !== 1'b1 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL cmd_accept: cmd_ready=%b, required 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    vectors++;
    if (op_en !== !rej) begin
      miscompares++;
      $display("FAIL op_en_latency op=%0d: op_en=%b, required %b", op, op_en, !rej);
    end
    budget = 0;
    while (!fin && budget < 300) begin
      if (rsp_valid === 1'b1) begin
        cur = {rsp_data, rsp_error, rsp_last};
        vectors++;
        if (cmd_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL cmd_ready_busy: cmd_ready=%b, required 0", cmd_ready);
        end
        if (holding) begin
          vectors++;
          if (cur !== held) begin
            miscompares++;
            $display("FAIL rsp_stable: got %h, required %h", cur, held);
          end
        end
        if (hold_left > 0) begin
          rsp_ready = 1'b0;
          hold_left--;
        end else begin
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
        if (rsp_ready) begin
          holding = 1'b0;
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL extra_beat op=%0d: got %h", op, cur);
            fin = 1'b1;
          end else begin
            want = exp_q.pop_front();
            if (cur !== want) begin
              miscompares++;
              $display("FAIL beat op=%0d: data=%h err=%b last=%b, required data=%h err=%b last=%b",
                       op, cur.data, cur.err, cur.last, want.data, want.err, want.last);
            end
            fin = cur.last;
          end
        end else begin
          holding = 1'b1;
          held = cur;
        end
      end else begin
        rsp_ready = ($urandom_range(0, 1) == 1);
      end
      @(negedge clk);
      budget++;
    end
    rsp_ready = 1'b0;
    vectors++;
    if (!fin || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rsp_complete op=%0d: finished=%b, beats left=%0d, required 1 and 0",
               op, fin, exp_q.size());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({cmd_ready, rsp_valid, rsp_error, rsp_last, op_en} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b, required 00000",
               {cmd_ready, rsp_valid, rsp_error, rsp_last, op_en});
    end
    vectors++;
    if ({rsp_data, op_sel, data_in, index_in} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got %h, required 0", {rsp_data, op_sel, data_in, index_in});
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_idle_ready: cmd_ready=%b, required 1", cmd_ready);
    end
  endtask

  task automatic test_write_read();
    run_cmd(3'd1, 32'hA5, 4'd3, 0);
    run_cmd(3'd0, 32'h0, 4'd3, 0);
  endtask

  task automatic test_find_all();
    for (int i = 0; i < LEN; i++) run_cmd(3'd1, (i == 1 || i == 4 || i == 6) ? 32'd7 : DW'(i + 20),
                                          LW'(i), 0);
    run_cmd(3'd2, 32'd7, 4'd0, 0);
  endtask

  task automatic test_find_first_miss();
    run_cmd(3'd3, 32'h55, 4'd0, 0);
  endtask

  task automatic test_sum_backpressure();
    for (int i = 0; i < LEN; i++) run_cmd(3'd1, DW'(i + 1), LW'(i), 0);
    run_cmd(3'd4, 32'h0, 4'd0, 0);
    run_cmd(3'd4, 32'h0, 4'd0, 5);
  endtask

  task automatic test_reject();
    int c = en_count;
    run_cmd(3'd7, 32'h1234, 4'd2, 0);
    run_cmd(3'd0, 32'h0, 4'd8, 0);
    run_cmd(3'd1, 32'hFF, 4'd15, 2);
    vectors++;
    if (en_count != c) begin
      miscompares++;
      $display("FAIL reject_no_op_en: op_en pulses=%0d, required 0", en_count - c);
    end
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < LEN; i++) run_cmd(3'd1, 32'h9, LW'(i), 0);
    run_cmd(3'd2, 32'h9, 4'd0, 3);
    run_cmd(3'd2, 32'h9, 4'd0, 0);
  endtask

  task automatic test_random();
    logic [2:0]    op;
    logic [DW-1:0] key;
    for (int n = 0; n < 60; n++) begin
      op  = 3'($urandom_range(0, 7));
      key = ($urandom_range(0, 4) == 0) ? DW'($urandom) : DW'($urandom_range(0, 3));
      run_cmd(op, key, LW'($urandom_range(0, 9)), $urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_mid_wait();
    stub_silent = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 3'd4;
    cmd_data = 32'h3C;
    cmd_index = 4'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (op_sel !== 3'd4) begin
      miscompares++;
      $display("FAIL midwait_op_sel: op_sel=%0d, required 4", op_sel);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({cmd_ready, rsp_valid, rsp_error, rsp_last, op_en} !== 5'b0) begin
      miscompares++;
      $display("FAIL midwait_reset_ctrl: got %b, required 00000",
               {cmd_ready, rsp_valid, rsp_error, rsp_last, op_en});
    end
    vectors++;
    if ({rsp_data, op_sel, data_in, index_in} !== '0) begin
      miscompares++;
      $display("FAIL midwait_reset_data: got %h, required 0",
               {rsp_data, op_sel, data_in, index_in});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stub_silent = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL midwait_after_reset: valid/ready=%b, required 01", {rsp_valid, cmd_ready});
    end
    run_cmd(3'd0, 32'h0, 4'd5, 0);
  endtask

`ifdef LIST_CMD_TIMEOUT_EN
  task automatic test_timeout();
    int cyc = 0;
    stub_silent = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 3'd2;
    cmd_data = 32'h1;
    cmd_index = 4'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (rsp_valid !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (cyc != TO + 1) begin
      miscompares++;
      $display("FAIL timeout_latency: %0d cycles after op_en, required %0d", cyc, TO + 1);
    end
    vectors++;
    if ({rsp_data, rsp_error, rsp_last} !== {{RW{1'b0}}, 2'b11}) begin
      miscompares++;
      $display("FAIL timeout_beat: got %h, required error+last", {rsp_data, rsp_error, rsp_last});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    stub_silent = 1'b0;
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_back_idle: cmd_ready=%b, required 1", cmd_ready);
    end
  endtask
`endif

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_data = '0;
    cmd_index = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_write_read();
    test_find_all();
    test_find_first_miss();
    test_sum_backpressure();
    test_reject();
    test_fifo_full();
    test_random();
    test_reset_mid_wait();
`ifdef LIST_CMD_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
